layer_stream_connector: RTL and testbench
=========================================

Name: layer_stream_connector

Overview:
Parametrised successor to the fixed 18-channel layer connector. Collects one result word per neuron from a layer of N_CH parallel neuron units, each with its own done flag, into a capture buffer. Once every channel has reported, streams the words out in channel order on an AXI4-Stream master with TLAST, optionally applying ReLU. Sits between consecutive neural-net layers, or between the last layer and the DMA/PS interface.

Parameters:
N_CH, 18, number of neuron channels (>=1)
DATA_W, 32, width of each neuron result and of m_tdata
RELU_EN, 0, 1 = clamp negative (signed, two's complement) words to 0 on output
DONE_EDGE, 0, 0 = capture while done is high (level); 1 = capture only on a 0->1 transition of done

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  arms one frame capture; sampled only in IDLE
n_data  in  N_CH*DATA_W  packed neuron results; channel i occupies bits [i*DATA_W +: DATA_W]
n_done  in  N_CH  per-channel result-valid flags
m_tdata  out  DATA_W  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  high on the final beat (channel N_CH-1)
busy  out  1  high in WAIT and STREAM
err_overrun  out  1  sticky: a channel reported done while in STREAM

Behaviour:
- Clock and reset: single clock clk; reset resetn is asynchronous, active-low.
- Reset values: state=IDLE, all captured flags 0, buffer 0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, err_overrun=0, beat index=0, done-edge history=0.
- Reset mid-frame aborts immediately with no partial output.
- IDX_W = max(1, $clog2(N_CH)).
- States:
  - IDLE:
    - start=1 at edge -> WAIT; clears captured flags and err_overrun.
    - start held high re-arms automatically after each frame.
  - WAIT:
    - Per edge, for each i with capture event (level: n_done[i]; edge: n_done[i] & ~prev[i]) and captured[i]=0: buf[i]<=n_data slice, captured[i]<=1.
    - A channel captures once per frame; later values are ignored.
    - When (captured | event) is all-ones at edge k: after edge k, state=STREAM, m_tvalid=1, m_tdata=f(buf[0]), m_tlast=(N_CH==1), index=0.
    - Latency from last done sampled to first tvalid: 1 cycle.
  - STREAM:
    - Handshake on m_tvalid & m_tready at an edge.
    - On a non-final handshake: index+1; m_tdata=f(buf[index+1]); m_tlast=(index+1==N_CH-1).
    - On the final handshake (m_tlast=1): m_tvalid=0, m_tlast=0 -> IDLE.
    - Without tready, m_tvalid/m_tdata/m_tlast hold stable (AXI-S rule).
    - m_tvalid never depends combinationally on m_tready.
    - With m_tready held high, one beat per cycle: N_CH cycles per frame.
    - Any capture event in STREAM sets err_overrun (sticky until next arm); the data is dropped.
    - start is ignored in STREAM.
- f(x) = (RELU_EN && x[DATA_W-1]) ? 0 : x. Applied on output only; the buffer holds raw values.
- DONE_EDGE=1: prev register updates every cycle in all states, so a done held high across frames does not recapture.
- DONE_EDGE=0: a done held high across frames recaptures in the cycle after arming.
- busy = (state != IDLE). Registered outputs only.

Decomposition:
- Package layer_conn_pkg: state enum (IDLE, WAIT, STREAM), the IDX_W clog2 helper function, and the ReLU function f.
- Sub-module layer_capture_bank: captured flags, DATA_W x N_CH buffer, done-edge detect, all_captured output, indexed read port.
- Top keeps the FSM and stream output regs.

Test Plan:
- Defaults, n_data channel i = i, start=1, resetn released at cycle 10, all n_done raised at cycle 20, m_tready=1 -> tvalid rises 1 cycle after done; beats 0..17 on consecutive cycles; tlast only with tdata=17; then IDLE and an immediate second identical frame (level mode).
- n_done bits raised in order 17 down to 0, one per cycle, each n_data changing after its done -> streamed words equal values at each channel's first done cycle; tvalid 1 cycle after channel 0 done.
- m_tready toggled 1,0,0,1 repeating -> tdata/tlast stable while stalled; all 18 beats delivered exactly once; no gaps beyond stalls.
- RELU_EN=1, DATA_W=16, N_CH=4, data {-5, 0, 7, 0x8000} -> stream {0, 0, 7, 0}, tlast on 4th beat.
- DONE_EDGE=1, n_done held high after frame 1, start held 1 -> no second frame until n_done drops and rises again; a pulse during STREAM sets err_overrun=1.
- resetn asserted at beat 5 of STREAM -> m_tvalid/busy/err_overrun go 0 asynchronously; after release with start=1 and dones, full frame from beat 0. N_CH=1 case: single beat with tlast=1.

Source files
------------

// File: rtl/layer_conn_pkg.sv
// Shared types and helpers for the layer stream connector: FSM states,
// index-width helper and the output ReLU decision.
package layer_conn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Beat index width; a single channel still needs one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // True when ReLU is on and the word is negative, i.e. the beat is forced to zero.
   function automatic logic relu_zero(input logic sign, input logic en);
      return en & sign;
   endfunction

endpackage

// File: rtl/layer_capture_bank.sv
// Per-channel capture buffer: one result word per neuron per frame, with
// optional rising-edge qualification of the done flags.
module layer_capture_bank
   import layer_conn_pkg::*;
#(
   parameter int N_CH      = 18,
   parameter int DATA_W    = 32,
   parameter int DONE_EDGE = 0,
   parameter int IDX_W     = 5
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear_i,
   input  logic                     cap_en_i,
   input  logic [N_CH*DATA_W-1:0]   n_data_i,
   input  logic [N_CH-1:0]          n_done_i,
   input  logic [IDX_W-1:0]         rd_idx_i,
   output logic                     all_captured_o,
   output logic                     event_any_o,
   output logic [DATA_W-1:0]        rd_data_o
);

   logic [N_CH-1:0]   prev_q;
   logic [N_CH-1:0]   captured_q, captured_d;
   logic [N_CH-1:0]   cap_ev;
   logic [N_CH-1:0]   take;
   logic [DATA_W-1:0] mem_q [N_CH];
   logic [DATA_W-1:0] mem_d [N_CH];

   always_comb begin
      cap_ev     = (DONE_EDGE != 0) ? (n_done_i & ~prev_q) : n_done_i;
      take       = cap_ev & ~captured_q & {N_CH{cap_en_i}};
      captured_d = clear_i ? '0 : (captured_q | take);
      for (int i = 0; i < N_CH; i++) begin
         mem_d[i] = take[i] ? n_data_i[i*DATA_W +: DATA_W] : mem_q[i];
      end
   end

   // Reads see the post-edge buffer so a word captured on the completing
   // edge can be launched as the first beat in the same cycle.
   assign rd_data_o      = mem_d[rd_idx_i];
   assign all_captured_o = &(captured_q | cap_ev);
   assign event_any_o    = |cap_ev;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_q     <= '0;
         captured_q <= '0;
         for (int i = 0; i < N_CH; i++) mem_q[i] <= '0;
      end else begin
         prev_q     <= n_done_i;
         captured_q <= captured_d;
         for (int i = 0; i < N_CH; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/layer_stream_connector.sv
// Collects one word per neuron channel and streams the frame out in channel
// order on an AXI4-Stream master with TLAST.
module layer_stream_connector
   import layer_conn_pkg::*;
#(
   parameter int N_CH      = 18,
   parameter int DATA_W    = 32,
   parameter int RELU_EN   = 0,
   parameter int DONE_EDGE = 0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [N_CH*DATA_W-1:0]   n_data,
   input  logic [N_CH-1:0]          n_done,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic                     busy,
   output logic                     err_overrun,
   output logic [1:0]               dbg_state_o
);

   localparam int IDX_W = idx_w(N_CH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

   // Stream handshake: a beat transfers on an edge where m_tvalid & m_tready;
   // m_tvalid/m_tdata/m_tlast are registers and hold while m_tready is low.
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, nxt_idx, rd_idx;
   logic              tvalid_q, tvalid_d, tlast_q, tlast_d, err_q, err_d;
   logic [DATA_W-1:0] tdata_q, tdata_d, rd_data, out_word;
   logic              clear, cap_en, all_cap, ev_any;

   layer_capture_bank #(
      .N_CH(N_CH), .DATA_W(DATA_W), .DONE_EDGE(DONE_EDGE), .IDX_W(IDX_W)
   ) u_bank (
      .clk(clk), .resetn(resetn), .clear_i(clear), .cap_en_i(cap_en),
      .n_data_i(n_data), .n_done_i(n_done), .rd_idx_i(rd_idx),
      .all_captured_o(all_cap), .event_any_o(ev_any), .rd_data_o(rd_data)
   );

   assign out_word = relu_zero(rd_data[DATA_W-1], RELU_EN != 0) ? '0 : rd_data;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      err_d    = err_q;
      clear    = 1'b0;
      cap_en   = 1'b0;
      nxt_idx  = idx_q + 1'b1;
      rd_idx   = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               clear   = 1'b1;
               err_d   = 1'b0;
            end
         end
         WAIT: begin
            cap_en = 1'b1;
            if (all_cap) begin
               state_d  = STREAM;
               tvalid_d = 1'b1;
               idx_d    = '0;
               tdata_d  = out_word;
               tlast_d  = (N_CH == 1);
            end
         end
         STREAM: begin
            rd_idx = tlast_q ? idx_q : nxt_idx;
            if (ev_any) err_d = 1'b1;
            if (tvalid_q && m_tready) begin
               if (tlast_q) begin
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  state_d  = IDLE;
               end else begin
                  idx_d   = nxt_idx;
                  tdata_d = out_word;
                  tlast_d = (nxt_idx == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         err_q    <= err_d;
      end
   end

   assign m_tvalid    = tvalid_q;
   assign m_tdata     = tdata_q;
   assign m_tlast     = tlast_q;
   assign err_overrun = err_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer_stream_connector.sv
// Scoreboard bench: four connector configurations (18ch level, 4ch ReLU,
// 4ch edge-detect, 1ch); stimulus pushes expected beats, monitors pop them.
module tb_layer_stream_connector;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: defaults (18 channels, 32 bit, level done)
   logic           a_start = 0, a_tready = 0;
   logic [18*32-1:0] a_data = '0;
   logic [17:0]    a_done = '0;
   logic [31:0]    a_tdata;
   logic           a_tvalid, a_tlast, a_busy, a_err;
   logic [1:0]     a_st;
   // DUT R: ReLU, 16 bit, 4 channels
   logic           r_start = 0, r_tready = 0;
   logic [4*16-1:0] r_data = '0;
   logic [3:0]     r_done = '0;
   logic [15:0]    r_tdata;
   logic           r_tvalid, r_tlast, r_busy, r_err;
   logic [1:0]     r_st;
   // DUT E: edge-qualified done, 4 channels
   logic           e_start = 0, e_tready = 0;
   logic [4*32-1:0] e_data = '0;
   logic [3:0]     e_done = '0;
   logic [31:0]    e_tdata;
   logic           e_tvalid, e_tlast, e_busy, e_err;
   logic [1:0]     e_st;
   // DUT S: single channel
   logic           s_start = 0, s_tready = 0;
   logic [31:0]    s_data = '0;
   logic [0:0]     s_done = '0;
   logic [31:0]    s_tdata;
   logic           s_tvalid, s_tlast, s_busy, s_err;
   logic [1:0]     s_st;

   logic [32:0] exp_a_q[$];
   logic [16:0] exp_r_q[$];
   logic [32:0] exp_e_q[$];
   logic [32:0] exp_s_q[$];

   layer_stream_connector dut_a (
      .clk(clk), .resetn(resetn), .start(a_start), .n_data(a_data), .n_done(a_done),
      .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(a_tready), .m_tlast(a_tlast),
      .busy(a_busy), .err_overrun(a_err), .dbg_state_o(a_st));

   layer_stream_connector #(.N_CH(4), .DATA_W(16), .RELU_EN(1), .DONE_EDGE(0)) dut_r (
      .clk(clk), .resetn(resetn), .start(r_start), .n_data(r_data), .n_done(r_done),
      .m_tdata(r_tdata), .m_tvalid(r_tvalid), .m_tready(r_tready), .m_tlast(r_tlast),
      .busy(r_busy), .err_overrun(r_err), .dbg_state_o(r_st));

   layer_stream_connector #(.N_CH(4), .DATA_W(32), .RELU_EN(0), .DONE_EDGE(1)) dut_e (
      .clk(clk), .resetn(resetn), .start(e_start), .n_data(e_data), .n_done(e_done),
      .m_tdata(e_tdata), .m_tvalid(e_tvalid), .m_tready(e_tready), .m_tlast(e_tlast),
      .busy(e_busy), .err_overrun(e_err), .dbg_state_o(e_st));

   layer_stream_connector #(.N_CH(1), .DATA_W(32), .RELU_EN(0), .DONE_EDGE(0)) dut_s (
      .clk(clk), .resetn(resetn), .start(s_start), .n_data(s_data), .n_done(s_done),
      .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_tready), .m_tlast(s_tlast),
      .busy(s_busy), .err_overrun(s_err), .dbg_state_o(s_st));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=no beat t=%0t", name, act, $time);
   endtask

   // Inputs change 2 time units after each rising edge; monitors sample on the falling edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic int qsize(input int which);
      case (which)
         0: return exp_a_q.size();
         1: return exp_r_q.size();
         2: return exp_e_q.size();
         default: return exp_s_q.size();
      endcase
   endfunction

   task automatic drain(input int which, input int max, output int cyc);
      cyc = 0;
      while (qsize(which) != 0 && cyc < max) begin
         tick();
         cyc++;
      end
      checks++;
      if (qsize(which) != 0) begin
         errors++;
         $display("FAIL drain_timeout_%0d actual=%0d beats left expected=0", which, qsize(which));
      end
   endtask

   // Monitors: pop and compare on each handshake; check hold stability while stalled.
   logic a_stall = 0, r_stall = 0, e_stall = 0, s_stall = 0;
   logic [32:0] a_hold, e_hold, s_hold;
   logic [16:0] r_hold;

   always @(negedge clk) begin
      if (!resetn) a_stall = 1'b0;
      else begin
         if (a_stall) begin
            chk("a_stall_valid", a_tvalid, 1);
            chk("a_stall_hold", {a_tlast, a_tdata}, a_hold);
         end
         if (a_tvalid && a_tready) begin
            if (exp_a_q.size() == 0) unexpected("a_beat", {a_tlast, a_tdata});
            else chk("a_beat", {a_tlast, a_tdata}, exp_a_q.pop_front());
         end
         a_stall = a_tvalid && !a_tready;
         a_hold  = {a_tlast, a_tdata};
      end
   end

   always @(negedge clk) begin
      if (!resetn) r_stall = 1'b0;
      else begin
         if (r_stall) chk("r_stall_hold", {r_tvalid, r_tlast, r_tdata}, {1'b1, r_hold});
         if (r_tvalid && r_tready) begin
            if (exp_r_q.size() == 0) unexpected("r_beat", {r_tlast, r_tdata});
            else chk("r_beat", {r_tlast, r_tdata}, exp_r_q.pop_front());
         end
         r_stall = r_tvalid && !r_tready;
         r_hold  = {r_tlast, r_tdata};
      end
   end

   always @(negedge clk) begin
      if (!resetn) e_stall = 1'b0;
      else begin
         if (e_stall) chk("e_stall_hold", {e_tvalid, e_tlast, e_tdata}, {1'b1, e_hold});
         if (e_tvalid && e_tready) begin
            if (exp_e_q.size() == 0) unexpected("e_beat", {e_tlast, e_tdata});
            else chk("e_beat", {e_tlast, e_tdata}, exp_e_q.pop_front());
         end
         e_stall = e_tvalid && !e_tready;
         e_hold  = {e_tlast, e_tdata};
      end
   end

   always @(negedge clk) begin
      if (!resetn) s_stall = 1'b0;
      else begin
         if (s_stall) chk("s_stall_hold", {s_tvalid, s_tlast, s_tdata}, {1'b1, s_hold});
         if (s_tvalid && s_tready) begin
            if (exp_s_q.size() == 0) unexpected("s_beat", {s_tlast, s_tdata});
            else chk("s_beat", {s_tlast, s_tdata}, exp_s_q.pop_front());
         end
         s_stall = s_tvalid && !s_tready;
         s_hold  = {s_tlast, s_tdata};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [3:0] pat;
      pat = 4'b1001;
      #1 resetn = 1'b0;

      // Frame 1/2: level mode, start held, all dones at cycle 20
      for (int i = 0; i < 18; i++) a_data[i*32 +: 32] = 32'(i);
      a_start  = 1'b1;
      a_tready = 1'b1;
      repeat (10) tick();
      chk("rst_a_tvalid", a_tvalid, 0);
      chk("rst_a_tdata", a_tdata, 0);
      chk("rst_a_tlast", a_tlast, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_a_state", a_st, 0);
      chk("rst_other_busy", {r_busy, e_busy, s_busy, s_tvalid}, 0);
      resetn = 1'b1;
      repeat (10) tick();
      chk("t1_wait_state", a_st, 1);
      chk("t1_tvalid_before_done", a_tvalid, 0);
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(i)});
      a_done = '1;
      tick();
      chk("t1_tvalid_latency", a_tvalid, 1);
      drain(0, 100, cyc);
      chk("t1_cycles_per_frame", cyc, 18);
      chk("t1_idle_after_last", {a_tvalid, a_busy}, 0);
      chk("t1_overrun_level", a_err, 1);
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(i)});
      tick();
      chk("t1_rearm_wait", {a_busy, a_err, a_tvalid}, 3'b100);
      tick();
      chk("t1_second_frame_valid", a_tvalid, 1);
      a_start = 1'b0;
      drain(0, 100, cyc);
      chk("t1_second_frame_cycles", cyc, 18);

      // Dones raised 17..0 one per cycle, data changes after each capture
      a_done = '0;
      for (int i = 0; i < 18; i++) a_data[i*32 +: 32] = 32'(100 + i);
      tick();
      chk("t2_idle", a_busy, 0);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("t2_armed", a_busy, 1);
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(100 + i)});
      for (int k = 0; k < 18; k++) begin
         int ch;
         ch = 17 - k;
         if (k == 17) chk("t2_no_valid_before_ch0", a_tvalid, 0);
         a_done[ch] = 1'b1;
         tick();
         a_data[ch*32 +: 32] = 32'hDEAD_0000 | 32'(ch);
      end
      chk("t2_tvalid_after_ch0", a_tvalid, 1);
      drain(0, 100, cyc);

      // Backpressure: tready 1,0,0,1 repeating
      a_done = '0;
      for (int i = 0; i < 18; i++) a_data[i*32 +: 32] = 32'(3*i + 7);
      tick();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(3*i + 7)});
      a_done = '1;
      tick();
      cyc = 0;
      while (exp_a_q.size() != 0 && cyc < 200) begin
         a_tready = pat[cyc % 4];
         chk("t3_no_gap", a_tvalid, 1);
         tick();
         cyc++;
      end
      chk("t3_all_beats", exp_a_q.size(), 0);
      a_tready = 1'b1;
      chk("t3_done", {a_tvalid, a_busy}, 0);

      // Reset at beat 5 of a stream
      a_done = '0;
      for (int i = 0; i < 18; i++) a_data[i*32 +: 32] = 32'(200 + i);
      tick();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(200 + i)});
      a_done = '1;
      tick();
      cyc = 0;
      while (exp_a_q.size() > 13 && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("t6_beat5_data", {a_tvalid, a_tdata}, {1'b1, 32'd205});
      chk("t6_err_before_reset", a_err, 1);
      resetn = 1'b0;
      #1;
      chk("t6_async_clear", {a_tvalid, a_busy, a_err, a_tlast}, 0);
      chk("t6_async_tdata", a_tdata, 0);
      exp_a_q.delete();
      tick();
      tick();
      for (int i = 0; i < 18; i++) exp_a_q.push_back({(i == 17), 32'(200 + i)});
      a_start = 1'b1;
      resetn  = 1'b1;
      tick();
      a_start = 1'b0;
      chk("t6_rearm", a_busy, 1);
      tick();
      chk("t6_restart_valid", {a_tvalid, a_tdata}, {1'b1, 32'd200});
      drain(0, 100, cyc);
      chk("t6_full_frame_cycles", cyc, 18);
      a_done = '0;

      // ReLU, 16 bit: {-5, 0, 7, 0x8000} -> {0, 0, 7, 0}
      r_data   = {16'h8000, 16'h0007, 16'h0000, 16'hFFFB};
      r_tready = 1'b1;
      r_start  = 1'b1;
      tick();
      r_start = 1'b0;
      exp_r_q.push_back(17'h00000);
      exp_r_q.push_back(17'h00000);
      exp_r_q.push_back(17'h00007);
      exp_r_q.push_back(17'h10000);
      r_done = '1;
      tick();
      chk("r_tvalid", r_tvalid, 1);
      drain(1, 50, cyc);
      chk("r_cycles", cyc, 4);

      // Edge mode: held done must not recapture; a new rising edge in STREAM is an overrun
      for (int i = 0; i < 4; i++) e_data[i*32 +: 32] = 32'(11 * (i + 1));
      e_tready = 1'b1;
      e_start  = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) exp_e_q.push_back({(i == 3), 32'(11 * (i + 1))});
      e_done = '1;
      tick();
      chk("e_tvalid", e_tvalid, 1);
      drain(2, 50, cyc);
      chk("e_cycles", cyc, 4);
      chk("e_no_overrun_on_held_done", e_err, 0);
      repeat (8) tick();
      chk("e_held_done_no_frame", {e_busy, e_tvalid, e_st}, {2'b10, 2'd1});
      e_tready = 1'b0;
      e_done   = '0;
      tick();
      for (int i = 0; i < 4; i++) e_data[i*32 +: 32] = 32'(11 * (i + 5));
      for (int i = 0; i < 4; i++) exp_e_q.push_back({(i == 3), 32'(11 * (i + 5))});
      e_done = '1;
      tick();
      chk("e_second_frame_valid", {e_tvalid, e_err}, 2'b10);
      e_start   = 1'b0;
      e_done[1] = 1'b0;
      tick();
      e_done[1] = 1'b1;
      tick();
      chk("e_overrun_set", e_err, 1);
      e_tready = 1'b1;
      drain(2, 50, cyc);
      chk("e_idle", e_busy, 0);

      // Single channel: one beat with tlast
      s_data   = 32'h1234_5678;
      s_tready = 1'b1;
      s_start  = 1'b1;
      tick();
      s_start = 1'b0;
      exp_s_q.push_back({1'b1, 32'h1234_5678});
      s_done = 1'b1;
      tick();
      chk("s_single_beat", {s_tvalid, s_tlast}, 2'b11);
      drain(3, 20, cyc);
      chk("s_after_beat", {s_tvalid, s_tlast, s_busy}, 0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
